// File: rtl/pipeline_pkg.sv
// Shared pipeline constants, the IF/ID record type and a PC increment helper.
package pipeline_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      word_t pc;
      word_t pc_plus4;
      word_t instr;
      logic  valid;
   } if_id_t;

   // Sequential fetch address; wraps modulo 2^XLEN.
   function automatic word_t pc_plus4(input word_t pc);
      return pc + word_t'(4);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: hazard controls, redirect, instruction-memory port and IF/ID outputs.
interface fetch_stage_if import pipeline_pkg::*;;

   logic  stall;
   logic  flush;
   logic  redirect_valid;
   word_t redirect_pc;
   word_t imem_pc;
   word_t imem_instr;
   word_t id_pc;
   word_t id_pc_plus4;
   word_t id_instr;
   logic  id_valid;

   // The fetch stage itself.
   modport master (
      input  stall, flush, redirect_valid, redirect_pc, imem_instr,
      output imem_pc, id_pc, id_pc_plus4, id_instr, id_valid
   );

   // Hazard unit, instruction memory and decode stage around it.
   modport slave (
      output stall, flush, redirect_valid, redirect_pc, imem_instr,
      input  imem_pc, id_pc, id_pc_plus4, id_instr, id_valid
   );

endinterface

// File: rtl/pc_reg.sv
// Program counter register with its next-PC selection.
module pc_reg import pipeline_pkg::*; #(
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  stall,
   input  logic  redirect_valid,
   input  word_t redirect_pc,
   output word_t pc
);

   word_t      pc_q;
   word_t      pc_next;
   logic [1:0] unused_redirect_lo;

   // Low target bits are forced to zero; instructions are word aligned.
   assign unused_redirect_lo = redirect_pc[1:0];

   // Next PC: a redirect beats stall so a taken target is never dropped.
   always_comb begin
      pc_next = pc_plus4(pc_q);
      if (redirect_valid) begin
         pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (stall) begin
         pc_next = pc_q;
      end
   end

   // PC register, synchronous reset to RESET_PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
module fetch_stage import pipeline_pkg::*; #(
   parameter word_t RESET_PC  = RESET_PC_DEFAULT,
   parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input logic          clk,
   input logic          rst,
   fetch_stage_if.master bus
);

   word_t  pc;
   if_id_t if_id_q;
   if_id_t if_id_next;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .rst            (rst),
      .stall          (bus.stall),
      .redirect_valid (bus.redirect_valid),
      .redirect_pc    (bus.redirect_pc),
      .pc             (pc)
   );

   // imem address comes straight from the PC register.
   assign bus.imem_pc = pc;

   // IF/ID next state: flush beats stall; a bubble keeps the PC fields.
   always_comb begin
      if_id_next.pc       = pc;
      if_id_next.pc_plus4 = pc_plus4(pc);
      if_id_next.instr    = bus.imem_instr;
      if_id_next.valid    = 1'b1;
      if (bus.flush) begin
         if_id_next       = if_id_q;
         if_id_next.instr = NOP_INSTR;
         if_id_next.valid = 1'b0;
      end else if (bus.stall) begin
         if_id_next = if_id_q;
      end
   end

   // IF/ID register, synchronous reset to an empty bubble at PC 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_q.pc       <= '0;
         if_id_q.pc_plus4 <= '0;
         if_id_q.instr    <= NOP_INSTR;
         if_id_q.valid    <= 1'b0;
      end else begin
         if_id_q <= if_id_next;
      end
   end

   assign bus.id_pc       = if_id_q.pc;
   assign bus.id_pc_plus4 = if_id_q.pc_plus4;
   assign bus.id_instr    = if_id_q.instr;
   assign bus.id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table with a scoreboard queue.
module tb_fetch_stage;
   import pipeline_pkg::*;

   localparam word_t TB_NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (TB_NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory stand-in: distinct word per address.
   function automatic word_t mem(input word_t a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   assign bus.imem_instr = mem(bus.imem_pc);

   typedef struct {
      logic  rst;
      logic  stall;
      logic  flush;
      logic  rv;
      word_t rpc;
      word_t e_pc;
      word_t e_idpc;
      word_t e_idpc4;
      word_t e_instr;
      logic  e_valid;
   } vec_t;

   typedef struct {
      word_t pc;
      word_t idpc;
      word_t idpc4;
      word_t instr;
      logic  valid;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];

   task automatic addv(input logic r, input logic s, input logic f, input logic rv,
                       input word_t rpc, input word_t epc, input word_t eidpc,
                       input word_t eidpc4, input word_t einstr, input logic ev);
      vec_t v;
      v.rst = r; v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
      v.e_pc = epc; v.e_idpc = eidpc; v.e_idpc4 = eidpc4;
      v.e_instr = einstr; v.e_valid = ev;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input word_t pc, input word_t idpc, input word_t idpc4,
                           input word_t instr, input logic valid);
      exp_t e;
      e.pc = pc; e.idpc = idpc; e.idpc4 = idpc4; e.instr = instr; e.valid = valid;
      sbq.push_back(e);
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
         return;
      end
      e = sbq.pop_front();
      check({tag, " imem_pc"},     bus.imem_pc,     e.pc);
      check({tag, " id_pc"},       bus.id_pc,       e.idpc);
      check({tag, " id_pc_plus4"}, bus.id_pc_plus4, e.idpc4);
      check({tag, " id_instr"},    bus.id_instr,    e.instr);
      check({tag, " id_valid"},    word_t'(bus.id_valid), word_t'(e.valid));
   endtask

   initial begin
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;

      //   rst s  f  rv rpc           pc            id_pc         id_pc+4       id_instr          valid
      addv(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        TB_NOP,            0); // reset
      addv(1, 1, 1, 1, 32'h40,       32'h0,        32'h0,        32'h0,        TB_NOP,            0); // reset beats all
      addv(0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        mem(32'h0),        1);
      addv(0, 0, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        mem(32'h4),        1);
      addv(0, 1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        mem(32'h4),        1); // stall x3
      addv(0, 1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        mem(32'h4),        1);
      addv(0, 1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        mem(32'h4),        1);
      addv(0, 0, 0, 0, 32'h0,        32'hC,        32'h8,        32'hC,        mem(32'h8),        1);
      addv(0, 0, 0, 0, 32'h0,        32'h10,       32'hC,        32'h10,       mem(32'hC),        1);
      addv(0, 0, 1, 1, 32'h40,       32'h40,       32'hC,        32'h10,       TB_NOP,            0); // redirect+flush
      addv(0, 0, 0, 0, 32'h0,        32'h44,       32'h40,       32'h44,       mem(32'h40),       1);
      addv(0, 1, 0, 1, 32'h83,       32'h80,       32'h40,       32'h44,       mem(32'h40),       1); // redirect under stall
      addv(0, 0, 0, 0, 32'h0,        32'h84,       32'h80,       32'h84,       mem(32'h80),       1);
      addv(0, 1, 1, 0, 32'h0,        32'h84,       32'h80,       32'h84,       TB_NOP,            0); // flush+stall
      addv(0, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h84,       32'h88,       mem(32'h84),       1); // redirect, no flush
      addv(0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        mem(32'hFFFFFFFC), 1); // wrap
      addv(0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        mem(32'h0),        1);
      addv(1, 1, 0, 1, 32'h200,      32'h0,        32'h0,        32'h0,        TB_NOP,            0); // reset mid-redirect
      addv(0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        mem(32'h0),        1);

      foreach (vecs[i]) begin
         rst                = vecs[i].rst;
         bus.stall          = vecs[i].stall;
         bus.flush          = vecs[i].flush;
         bus.redirect_valid = vecs[i].rv;
         bus.redirect_pc    = vecs[i].rpc;
         push_exp(vecs[i].e_pc, vecs[i].e_idpc, vecs[i].e_idpc4, vecs[i].e_instr, vecs[i].e_valid);
         @(posedge clk);
         #1;
         pop_compare($sformatf("vec%0d", i));
      end

      // imem_pc must not react to inputs before the clock edge.
      rst = 1'b1;
      bus.stall = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h1234_5678;
      #2;
      check("imem_pc comb isolation", bus.imem_pc, 32'h4);
      rst = 1'b0;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;

      // Free-run throughput: one instruction per cycle.
      for (int k = 0; k < 6; k++) begin
         push_exp(word_t'(8 + 4 * k), word_t'(4 + 4 * k), word_t'(8 + 4 * k),
                  mem(word_t'(4 + 4 * k)), 1'b1);
         @(posedge clk);
         #1;
         pop_compare($sformatf("run%0d", k));
      end

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d leftover expected 0", sbq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word injected as a bubble.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port stall, input, 1, which holds the PC and the IF/ID register.
REQ-006 SHALL have port flush, input, 1, which loads a bubble into IF/ID.
REQ-007 SHALL have port redirect_valid, input, 1, which marks a taken branch or jump.
REQ-008 SHALL have port redirect_pc, input, 32, the branch or jump target byte address.
REQ-009 SHALL have port imem_pc, output, 32, the current fetch byte address driven to instruction memory.
REQ-010 SHALL have port imem_instr, input, 32, the combinational instruction-memory read data for imem_pc.
REQ-011 SHALL have port id_pc, output, 32, the PC of the instruction held in IF/ID.
REQ-012 SHALL have port id_pc_plus4, output, 32, equal to id_pc + 4.
REQ-013 SHALL have port id_instr, output, 32, the instruction held in IF/ID.
REQ-014 SHALL have port id_valid, output, 1, set when IF/ID holds a real instruction and clear for a bubble.

Function
REQ-015 SHALL drive imem_pc directly from the PC register with no combinational path from any input.
REQ-016 SHALL select the PC next-state by priority: rst → RESET_PC; redirect_valid → {redirect_pc[31:2],2'b00}; stall → hold; otherwise PC+4.
REQ-017 SHALL give redirect_valid priority over stall for the PC update, so a target is never lost while the pipe is stalled.
REQ-018 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-019 SHALL select the IF/ID next-state by priority: rst → reset values; flush → bubble; stall → hold; otherwise capture {imem_pc, imem_pc+4, imem_instr, 1}.
REQ-020 SHALL form a bubble as id_instr=NOP_INSTR and id_valid=0, with id_pc and id_pc_plus4 unchanged.
REQ-021 SHALL, when flush and stall are both high, insert a bubble (flush wins).
REQ-022 SHALL leave IF/ID content under the IF/ID priority of REQ-019 only, independent of redirect_valid; the hazard unit asserts flush alongside redirect.
REQ-023 SHALL have a latency of one edge, from imem_pc presenting address A to id_instr=mem[A] and id_pc=A.
REQ-024 SHALL sustain a throughput of one instruction per cycle with stall=flush=0.

Reset
REQ-025 SHALL, at the edge with rst=1: set PC=RESET_PC, id_pc=0, id_pc_plus4=0, id_instr=NOP_INSTR, id_valid=0.
REQ-026 SHALL let rst override stall, flush and redirect, including mid-stall and mid-redirect.
REQ-027 SHALL, in the first cycle after rst deasserts, have imem_pc=RESET_PC, and at the following edge have id_valid=1.

Structure
REQ-028 SHALL take the constants XLEN=32, NOP_INSTR and RESET_PC default from the shared package pipeline_pkg.
REQ-029 SHALL isolate the PC register and next-PC mux in one sub-module, pc_reg; the IF/ID register SHALL stay in fetch_stage.
REQ-030 SHALL contain no memory; fetch_stage SHALL connect externally to the existing instruction memory.

Verification
REQ-031 SHALL be checked for reset: rst=1 for 2 cycles then release, with RESET_PC=0 → imem_pc 0,4,8; id_valid 0 then 1; id_pc 0 then 4.
REQ-032 SHALL be checked for stall: stall=1 for 3 cycles at pc=8 → imem_pc stays 8; id_pc stays 4; resumes at 12 after release.
REQ-033 SHALL be checked for redirect plus flush: redirect_valid=1, redirect_pc=0x40, flush=1 at pc=0x10 → next imem_pc=0x40, id_valid=0; the edge after, id_pc=0x40.
REQ-034 SHALL be checked for redirect under stall: stall=1 with redirect_pc=0x83 → imem_pc=0x80; IF/ID held.
REQ-035 SHALL be checked for wrap-around: redirect to 0xFFFF_FFFC, then free-run → imem_pc=0; id_pc_plus4=0 for the 0xFFFF_FFFC instruction.
REQ-036 SHALL be checked for flush with stall: flush=stall=1 → id_instr=NOP_INSTR, id_valid=0, PC held.
